vivo_fifo_flex: RTL and testbench
=================================

# vivo_fifo_flex

Next-generation variable-input/variable-output FIFO. Accepts 0..IN_ELEMS_MAX elements per push beat and delivers up to OUT_ELEMS_MAX elements per pop beat from a single circular element store. Adds optional partial pops, synchronous flush, a fill-level output and almost-full/almost-empty flags. It sits between width-mismatched producers and consumers in the streaming datapath.

## Interface
Parameters:
- ELEM_WIDTH, 8, bits per element
- DEPTH, 64, total element capacity; any integer ≥ max(IN_ELEMS_MAX, OUT_ELEMS_MAX), not required to be a power of 2
- IN_ELEMS_MAX, 4, max elements per push beat
- OUT_ELEMS_MAX, 4, max elements per pop beat
- PARTIAL_EN, 1, 1 = pop may return fewer elements than requested; 0 = all-or-nothing
- AF_THRESH, DEPTH-IN_ELEMS_MAX, almost_full asserts when level ≥ AF_THRESH
- AE_THRESH, OUT_ELEMS_MAX, almost_empty asserts when level ≤ AE_THRESH

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous discard of all contents
- in_valid  in  1  push request
- in_ready  out  1  push accepted when in_valid && in_ready
- in_data  in  IN_ELEMS_MAX×ELEM_WIDTH  element j in slice j; j=0 enters first
- in_num_elems  in  $clog2(IN_ELEMS_MAX+1)  elements in this beat
- out_valid  out  1  pop data available
- out_ready  in  1  consumer takes the beat when out_valid && out_ready
- out_req_elems  in  $clog2(OUT_ELEMS_MAX+1)  elements requested
- out_data  out  OUT_ELEMS_MAX×ELEM_WIDTH  slice i = i-th oldest element
- out_num_elems  out  $clog2(OUT_ELEMS_MAX+1)  elements delivered this beat
- level  out  $clog2(DEPTH+1)  current stored element count
- almost_full  out  1  level ≥ AF_THRESH
- almost_empty  out  1  level ≤ AE_THRESH

## Operation
- State: mem[DEPTH], wr_ptr, rd_ptr (0..DEPTH-1), count (0..DEPTH). Pointer advance: p+n; subtract DEPTH if result ≥ DEPTH (n ≤ DEPTH, so one subtraction suffices).
- free = DEPTH − count. in_ready = (in_num_elems ≠ 0) && (in_num_elems ≤ free) && !flush. in_num_elems > IN_ELEMS_MAX is illegal input; behaviour is undefined.
- Push fire: write in_data[j] to mem[(wr_ptr+j) mod DEPTH] for j < in_num_elems; wr_ptr += in_num_elems.
- Pop grant n_out: if out_req_elems = 0 or count = 0, n_out = 0. Otherwise, PARTIAL_EN=1 gives n_out = min(out_req_elems, count); PARTIAL_EN=0 gives n_out = out_req_elems if count ≥ out_req_elems, else 0.
- out_valid = (n_out ≠ 0) && !flush. out_num_elems = n_out when out_valid, else 0.
- out_data[i] = mem[(rd_ptr+i) mod DEPTH] for i < out_num_elems; unused slices drive 0.
- Pop fire: rd_ptr += n_out.
- count_next = count + push_n − pop_n, where push_n and pop_n are zero if the corresponding side does not fire.
- Push and pop in the same cycle are both allowed. in_ready is computed from the current count only, with no credit for a same-cycle pop. Elements pushed in a cycle are not visible to pop until the next cycle.
- flush = 1 has priority: pointers and count go to 0, no push or pop fires, and mem contents are don't-care.
- level = count. almost_full and almost_empty are decoded from registered count and have no extra latency.
- out_req_elems and out_num_elems may change while out_valid = 1 and out_ready = 0. Data is not held stable; the consumer samples on the fire cycle only.

## Timing
- Reset values (async assert, sync-safe deassert): pointers and count = 0; in_ready = 0 until in_num_elems ≠ 0; out_valid = 0, out_num_elems = 0, out_data = 0, level = 0, almost_full = (AF_THRESH == 0), almost_empty = 1.
- Push-to-pop latency: 1 cycle. An element written at edge k is poppable in cycle k+1.
- Pop is combinational from registered state plus out_req_elems. There is no pipeline bubble, and back-to-back pops each cycle are allowed.
- Full (count = DEPTH): in_ready = 0 for every in_num_elems, even when a pop fires in the same cycle.
- Empty: out_valid = 0 for both PARTIAL_EN settings.
- Wrap: multi-element pushes and pops straddle mem index DEPTH−1 → 0 seamlessly, including when DEPTH is not a power of 2.
- Reset asserted mid-transfer: everything is cleared immediately, and nothing in flight is completed.

## Test plan
- DEPTH=10, IN=OUT=4, PARTIAL_EN=1: push 3 (A,B,C) → next cycle, out_req_elems=4 gives out_valid=1, out_num_elems=3, out_data={0,C,B,A}; after the pop, level=0 and almost_empty=1.
- PARTIAL_EN=0, count=3, req=4 → out_valid=0. Push 1 more → next cycle out_valid=1, out_num_elems=4.
- Fill to 10 via pushes of 4,4,2 → level=10, in_ready=0 for in_num_elems=1. Simultaneously pop 4 with in_valid on: no push accepted; the next cycle gives level=6 and in_ready=1 for in_num_elems ≤ 4.
- Wrap with DEPTH=10: push 4 and pop 4 repeatedly for 20 cycles with an incrementing pattern → output order matches input exactly across the 9→0 boundary.
- Flush with count=7 while in_valid=1 and out_ready=1 → in_ready=0 and out_valid=0 that cycle; next cycle level=0 and the pushed data is discarded.
- Async reset pulse mid-stream (count=5) → all outputs take reset values within the same cycle; after release, a push of 2 is popped correctly with level returning to 0.

Source files
------------

// File: rtl/vivo_fifo_flex_if.sv
// Streaming port bundle for vivo_fifo_flex: push side, pop side, flush and
// the occupancy status outputs. The FIFO uses the slave modport.
interface vivo_fifo_flex_if #(
    parameter int ELEM_WIDTH    = 8,
    parameter int DEPTH         = 64,
    parameter int IN_ELEMS_MAX  = 4,
    parameter int OUT_ELEMS_MAX = 4
);
    localparam int IW = $clog2(IN_ELEMS_MAX + 1);
    localparam int OW = $clog2(OUT_ELEMS_MAX + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic                                flush;
    logic                                in_valid;
    logic                                in_ready;
    logic [IN_ELEMS_MAX*ELEM_WIDTH-1:0]  in_data;
    logic [IW-1:0]                       in_num_elems;
    logic                                out_valid;
    logic                                out_ready;
    logic [OW-1:0]                       out_req_elems;
    logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0] out_data;
    logic [OW-1:0]                       out_num_elems;
    logic [CW-1:0]                       level;
    logic                                almost_full;
    logic                                almost_empty;

    modport master (
        output flush, in_valid, in_data, in_num_elems, out_ready, out_req_elems,
        input  in_ready, out_valid, out_data, out_num_elems, level,
               almost_full, almost_empty
    );

    modport slave (
        input  flush, in_valid, in_data, in_num_elems, out_ready, out_req_elems,
        output in_ready, out_valid, out_data, out_num_elems, level,
               almost_full, almost_empty
    );
endinterface

// File: rtl/vivo_fifo_flex.sv
// Variable-in / variable-out element FIFO over one circular store.
// Pushes of 0..IN_ELEMS_MAX elements, pops of up to OUT_ELEMS_MAX elements,
// same-cycle push and pop, synchronous flush, level and almost flags.
module vivo_fifo_flex #(
    parameter int ELEM_WIDTH    = 8,
    parameter int DEPTH         = 64,
    parameter int IN_ELEMS_MAX  = 4,
    parameter int OUT_ELEMS_MAX = 4,
    parameter bit PARTIAL_EN    = 1'b1,
    parameter int AF_THRESH     = DEPTH - IN_ELEMS_MAX,
    parameter int AE_THRESH     = OUT_ELEMS_MAX
) (
    input logic             clk,
    input logic             rst_n,
    vivo_fifo_flex_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int IW = $clog2(IN_ELEMS_MAX + 1);
    localparam int OW = $clog2(OUT_ELEMS_MAX + 1);
    localparam int EW = ELEM_WIDTH;

    typedef logic [EW-1:0] elem_t;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    elem_t w_mem [DEPTH];

    // Circular advance; the step never exceeds DEPTH, so one subtraction
    // brings the sum back into range for any DEPTH, power of two or not.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p,
                                              input logic [CW-1:0] n);
        logic [SW-1:0] s;
        s = SW'(p) + SW'(n);
        if (s >= SW'(DEPTH)) s = s - SW'(DEPTH);
        return PW'(s);
    endfunction

    // ---------------- push side ----------------
    logic [IW-1:0] w_in_num;
    logic [CW-1:0] w_free;
    logic          w_in_ready;
    logic          w_push_fire;
    logic [CW-1:0] w_push_n;

    assign w_in_num    = bus.in_num_elems;
    assign w_free      = CW'(DEPTH) - r_count;
    // No credit for a same-cycle pop: acceptance looks at the current count only.
    assign w_in_ready  = (w_in_num != '0) && (CW'(w_in_num) <= w_free) && !bus.flush;
    assign w_push_fire = bus.in_valid && w_in_ready;
    assign w_push_n    = w_push_fire ? CW'(w_in_num) : '0;

    // ---------------- pop side ----------------
    logic [OW-1:0] w_req;
    logic [OW-1:0] w_n_out;
    logic          w_out_valid;
    logic [OW-1:0] w_out_num;
    logic [CW-1:0] w_pop_n;
    logic [OUT_ELEMS_MAX*EW-1:0] w_out_data;

    // Grant size from the registered count; requests above the slice count are capped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_req   = bus.out_req_elems;
        w_n_out = '0;
        if (32'(w_req) > 32'(OUT_ELEMS_MAX)) w_req = OW'(OUT_ELEMS_MAX);
        if ((w_req != '0) && (r_count != '0)) begin
            if (CW'(w_req) <= r_count) begin
                w_n_out = w_req;
            end else if (PARTIAL_EN) begin
                // count < req <= OUT_ELEMS_MAX here, so it fits the grant width.
                w_n_out = OW'(r_count);
            end
        end
    end

    assign w_out_valid = (w_n_out != '0) && !bus.flush;
    assign w_out_num   = w_out_valid ? w_n_out : '0;
    assign w_pop_n     = (w_out_valid && bus.out_ready) ? CW'(w_n_out) : '0;

    // Present the oldest elements in slice order; unused slices read as zero.
    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < OUT_ELEMS_MAX; i++) begin
            if (OW'(i) < w_out_num) begin
                w_out_data[i*EW +: EW] = w_mem[ptr_add(r_rd_ptr, CW'(i))];
            end
        end
    end

    // ---------------- element store ----------------
    logic [DEPTH-1:0] w_we;
    elem_t            w_wdata [DEPTH];

    // Scatter the push beat onto the entries it covers, wrapping past DEPTH-1.
    always_comb begin
        w_we = '0;
        for (int k = 0; k < DEPTH; k++) w_wdata[k] = '0;
        for (int j = 0; j < IN_ELEMS_MAX; j++) begin
            if (w_push_fire && (IW'(j) < w_in_num)) begin
                w_we[ptr_add(r_wr_ptr, CW'(j))]    = 1'b1;
                w_wdata[ptr_add(r_wr_ptr, CW'(j))] = bus.in_data[j*EW +: EW];
            end
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_mem
        elem_t r_entry;

        // Entry k captures its element only when the push window covers it.
        always_ff @(posedge clk) begin
            // NOTE: the store is not reset; count gates every read, so stale data is never visible.
            if (w_we[k]) r_entry <= w_wdata[k];
        end

        assign w_mem[k] = r_entry;
    end

    // ---------------- bookkeeping ----------------
    // Pointers and occupancy; flush empties the FIFO at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= ptr_add(r_wr_ptr, w_push_n);
            r_rd_ptr <= ptr_add(r_rd_ptr, w_pop_n);
            r_count  <= r_count + w_push_n - w_pop_n;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = w_out_valid;
    assign bus.out_num_elems = w_out_num;
    assign bus.out_data      = w_out_data;
    assign bus.level         = r_count;
    assign bus.almost_full   = ($signed({1'b0, 32'(r_count)}) >= 33'(AF_THRESH));
    assign bus.almost_empty  = ($signed({1'b0, 32'(r_count)}) <= 33'(AE_THRESH));

endmodule

// File: tb/tb_vivo_fifo_flex.sv
// Self-checking bench for vivo_fifo_flex (DEPTH=10, 4 in / 4 out).
// Two instances see identical stimulus: one with partial pops, one all-or-nothing.
// Each is tracked by an element-queue reference model.
module tb_vivo_fifo_flex;
    localparam int D     = 10;
    localparam int IN_M  = 4;
    localparam int OUT_M = 4;
    localparam int AF_T  = D - IN_M;
    localparam int AE_T  = OUT_M;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vivo_fifo_flex_if #(.ELEM_WIDTH(8), .DEPTH(D), .IN_ELEMS_MAX(IN_M), .OUT_ELEMS_MAX(OUT_M)) bp ();
    vivo_fifo_flex_if #(.ELEM_WIDTH(8), .DEPTH(D), .IN_ELEMS_MAX(IN_M), .OUT_ELEMS_MAX(OUT_M)) ba ();

    vivo_fifo_flex #(.ELEM_WIDTH(8), .DEPTH(D), .IN_ELEMS_MAX(IN_M), .OUT_ELEMS_MAX(OUT_M),
                     .PARTIAL_EN(1'b1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(bp));
    vivo_fifo_flex #(.ELEM_WIDTH(8), .DEPTH(D), .IN_ELEMS_MAX(IN_M), .OUT_ELEMS_MAX(OUT_M),
                     .PARTIAL_EN(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: element queues, oldest at index 0.
    logic [7:0] q_p [$];
    logic [7:0] q_a [$];

    logic        cur_fl, cur_iv, cur_ordy;
    int          cur_n, cur_req;
    logic [31:0] cur_data;
    logic        exp_ir [2];
    logic        exp_ov [2];
    int          exp_g  [2];
    int          nxt = 1;

    typedef struct {
        logic fl; logic iv; int n; logic ordy; int req;
        logic e_ir; logic e_ov; int e_on; int e_lvl;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q_p.size() : q_a.size();
    endfunction

    function automatic logic [7:0] q_at(input int k, input int i);
        return (k == 0) ? q_p[i] : q_a[i];
    endfunction

    function automatic logic [31:0] pat();
        logic [31:0] d;
        for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(nxt + j);
        nxt += 4;
        return d;
    endfunction

    task automatic apply(input logic fl, input logic iv, input int n, input logic ordy,
                         input int req, input logic [31:0] d);
        cur_fl = fl; cur_iv = iv; cur_n = n; cur_ordy = ordy; cur_req = req; cur_data = d;
        bp.flush = fl; bp.in_valid = iv; bp.in_num_elems = 3'(n); bp.in_data = d;
        bp.out_ready = ordy; bp.out_req_elems = 3'(req);
        ba.flush = fl; ba.in_valid = iv; ba.in_num_elems = 3'(n); ba.in_data = d;
        ba.out_ready = ordy; ba.out_req_elems = 3'(req);
        #1;
    endtask

    // Compare both instances against the model for the inputs now applied.
    task automatic check_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            int          sz;
            int          g;
            logic [31:0] ed;
            string       nm;
            logic        a_ir, a_ov, a_af, a_ae;
            logic [31:0] a_d;
            int          a_on, a_lvl;
            sz = q_size(k);
            nm = (k == 0) ? "part" : "aon";
            g  = 0;
            if (cur_req != 0 && sz != 0) begin
                if (k == 0) g = (cur_req < sz) ? cur_req : sz;
                else        g = (sz >= cur_req) ? cur_req : 0;
            end
            exp_g[k]  = g;
            exp_ov[k] = (g != 0) && !cur_fl;
            exp_ir[k] = !cur_fl && cur_n != 0 && cur_n <= D - sz;
            ed = '0;
            if (exp_ov[k]) for (int i = 0; i < g; i++) ed[i*8 +: 8] = q_at(k, i);
            if (k == 0) begin
                a_ir = bp.in_ready; a_ov = bp.out_valid; a_on = int'(bp.out_num_elems);
                a_d = bp.out_data; a_lvl = int'(bp.level); a_af = bp.almost_full; a_ae = bp.almost_empty;
            end else begin
                a_ir = ba.in_ready; a_ov = ba.out_valid; a_on = int'(ba.out_num_elems);
                a_d = ba.out_data; a_lvl = int'(ba.level); a_af = ba.almost_full; a_ae = ba.almost_empty;
            end
            check($sformatf("%s/%s in_ready", tag, nm), 64'(a_ir), 64'(exp_ir[k]));
            check($sformatf("%s/%s out_valid", tag, nm), 64'(a_ov), 64'(exp_ov[k]));
            check($sformatf("%s/%s out_num", tag, nm), 64'(a_on), 64'(exp_ov[k] ? g : 0));
            check($sformatf("%s/%s out_data", tag, nm), 64'(a_d), 64'(ed));
            check($sformatf("%s/%s level", tag, nm), 64'(a_lvl), 64'(sz));
            check($sformatf("%s/%s almost_full", tag, nm), 64'(a_af), 64'(sz >= AF_T));
            check($sformatf("%s/%s almost_empty", tag, nm), 64'(a_ae), 64'(sz <= AE_T));
        end
    endtask

    // Clock edge, then update the model with whatever fired.
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (cur_fl) begin
                if (k == 0) q_p.delete(); else q_a.delete();
            end else begin
                if (exp_ov[k] && cur_ordy) begin
                    for (int i = 0; i < exp_g[k]; i++) begin
                        if (k == 0) void'(q_p.pop_front()); else void'(q_a.pop_front());
                    end
                end
                if (exp_ir[k] && cur_iv) begin
                    for (int j = 0; j < cur_n; j++) begin
                        if (k == 0) q_p.push_back(cur_data[j*8 +: 8]);
                        else        q_a.push_back(cur_data[j*8 +: 8]);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic step(input string tag, input logic fl, input logic iv, input int n,
                        input logic ordy, input int req, input logic [31:0] d);
        apply(fl, iv, n, ordy, req, d);
        check_model(tag);
        advance();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " part level"}, 64'(bp.level), 64'd0);
        check({tag, " part out_valid"}, 64'(bp.out_valid), 64'd0);
        check({tag, " part out_num"}, 64'(bp.out_num_elems), 64'd0);
        check({tag, " part out_data"}, 64'(bp.out_data), 64'd0);
        check({tag, " part in_ready"}, 64'(bp.in_ready), 64'd0);
        check({tag, " part almost_empty"}, 64'(bp.almost_empty), 64'd1);
        check({tag, " part almost_full"}, 64'(bp.almost_full), 64'd0);
        check({tag, " aon level"}, 64'(ba.level), 64'd0);
        check({tag, " aon out_valid"}, 64'(ba.out_valid), 64'd0);
        check({tag, " aon almost_empty"}, 64'(ba.almost_empty), 64'd1);
    endtask

    vec_t vecs [17];

    initial begin
        // Hand-derived expectations for the partial-pop instance, starting empty.
        //            fl    iv    n  ordy  req  ir    ov    on lvl
        vecs[0]  = '{1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0};   // idle after reset
        vecs[1]  = '{1'b0, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 0, 0};   // push A,B,C
        vecs[2]  = '{1'b0, 1'b0, 0, 1'b1, 4, 1'b0, 1'b1, 3, 3};   // partial pop of 3
        vecs[3]  = '{1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0};   // empty again
        vecs[4]  = '{1'b0, 1'b1, 1, 1'b1, 4, 1'b1, 1'b0, 0, 0};   // 4th element for all-or-nothing
        vecs[5]  = '{1'b0, 1'b0, 0, 1'b0, 4, 1'b0, 1'b1, 1, 1};   // offered, not taken
        vecs[6]  = '{1'b1, 1'b1, 2, 1'b1, 4, 1'b0, 1'b0, 0, 1};   // flush
        vecs[7]  = '{1'b0, 1'b1, 4, 1'b0, 0, 1'b1, 1'b0, 0, 0};   // fill 4
        vecs[8]  = '{1'b0, 1'b1, 4, 1'b0, 0, 1'b1, 1'b0, 0, 4};   // fill 4
        vecs[9]  = '{1'b0, 1'b1, 2, 1'b0, 0, 1'b1, 1'b0, 0, 8};   // fill 2, exactly free
        vecs[10] = '{1'b0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 0, 10};  // full rejects 1
        vecs[11] = '{1'b0, 1'b1, 1, 1'b1, 4, 1'b0, 1'b1, 4, 10};  // full, pop does not free push
        vecs[12] = '{1'b0, 1'b0, 4, 1'b0, 0, 1'b1, 1'b0, 0, 6};   // 4 free now
        vecs[13] = '{1'b0, 1'b1, 3, 1'b0, 0, 1'b1, 1'b0, 0, 6};   // to 9
        vecs[14] = '{1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 1'b1, 2, 9};   // to 7
        vecs[15] = '{1'b1, 1'b1, 2, 1'b1, 4, 1'b0, 1'b0, 0, 7};   // flush at 7 with traffic
        vecs[16] = '{1'b0, 1'b0, 0, 1'b1, 4, 1'b0, 1'b0, 0, 0};   // pushed data discarded

        rst_n = 1'b0;
        apply(1'b0, 1'b0, 0, 1'b0, 0, 32'h0);
        #1;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors
        foreach (vecs[v]) begin
            apply(vecs[v].fl, vecs[v].iv, vecs[v].n, vecs[v].ordy, vecs[v].req, pat());
            check($sformatf("vec%0d in_ready", v), 64'(bp.in_ready), 64'(vecs[v].e_ir));
            check($sformatf("vec%0d out_valid", v), 64'(bp.out_valid), 64'(vecs[v].e_ov));
            check($sformatf("vec%0d out_num", v), 64'(bp.out_num_elems), 64'(vecs[v].e_on));
            check($sformatf("vec%0d level", v), 64'(bp.level), 64'(vecs[v].e_lvl));
            check_model($sformatf("vec%0d", v));
            advance();
        end

        // Wrap: steady push-4/pop-4 streaming straddles index 9 -> 0 many times
        step("wrap_fill", 1'b0, 1'b1, 4, 1'b0, 0, pat());
        for (int c = 0; c < 20; c++) step($sformatf("wrap%0d", c), 1'b0, 1'b1, 4, 1'b1, 4, pat());
        step("wrap_drain", 1'b0, 1'b0, 0, 1'b1, 4, 32'h0);
        check("wrap end level", 64'(bp.level), 64'd0);

        // Asynchronous reset mid-stream with 5 stored
        step("pre_rst_a", 1'b0, 1'b1, 4, 1'b0, 0, pat());
        step("pre_rst_b", 1'b0, 1'b1, 1, 1'b0, 0, pat());
        apply(1'b0, 1'b0, 0, 1'b0, 4, 32'h0);
        check_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q_p.delete();
        q_a.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst_push", 1'b0, 1'b1, 2, 1'b0, 0, pat());
        step("post_rst_pop", 1'b0, 1'b0, 0, 1'b1, 2, 32'h0);
        check("post_rst part level", 64'(bp.level), 64'd0);
        check("post_rst aon level", 64'(ba.level), 64'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            step($sformatf("rnd%0d", c),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, IN_M)),
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, OUT_M)),
                 $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
